execute_sequencer: RTL and testbench



---
 rtl/execute_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_execute_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_sequencer.sv
// Execute-phase sequencer for the 8-bit SAP core: decodes the latched
// opcode and drives datapath strobes one step per clock.
// Ports: clk, rst (sync, active-high), start/opcode from fetch,
//   carry_flag/zero_flag from ALU flags; busy/done/halted/illegal/step_out
//   status back to fetch; ir_out..out_load datapath control strobes.
module execute_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic                busy,
    output logic                done,
    output logic                halted,
    output logic                illegal,
    output logic [STEP_W-1:0]   step_out,
    output logic                ir_out,
    output logic                mar_load,
    output logic                ram_read,
    output logic                ram_write,
    output logic                a_load,
    output logic                a_out,
    output logic                b_load,
    output logic                alu_out,
    output logic                alu_sub,
    output logic                flags_load,
    output logic                pc_load,
    output logic                out_load
);

    typedef enum logic [2:0] {
        IDLE, S1, S2, S3, DONE, HALT
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [1:0]          nsteps;

    // Step count per opcode; 0 covers NOP, HLT and undefined opcodes.
    function automatic logic [1:0] steps_of(input logic [OPCODE_W-1:0] op);
        logic [1:0] n;
        n = 2'd0;
        case (op)
            OP_LDA, OP_STA:                         n = 2'd2;
            OP_ADD, OP_SUB:                         n = 2'd3;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT:   n = 2'd1;
            default:                                n = 2'd0;
        endcase
        return n;
    endfunction

    assign nsteps = steps_of(op_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        done       = 1'b0;
        illegal    = 1'b0;
        step_out   = '0;
        ir_out     = 1'b0;
        mar_load   = 1'b0;
        ram_read   = 1'b0;
        ram_write  = 1'b0;
        a_load     = 1'b0;
        a_out      = 1'b0;
        b_load     = 1'b0;
        alu_out    = 1'b0;
        alu_sub    = 1'b0;
        flags_load = 1'b0;
        pc_load    = 1'b0;
        out_load   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = opcode;
                    if (opcode == OP_HLT)
                        state_d = HALT;
                    else if (steps_of(opcode) == 2'd0)
                        state_d = DONE;
                    else
                        state_d = S1;
                end
            end
            S1: begin
                step_out = STEP_W'(1);
                state_d  = (nsteps == 2'd1) ? DONE : S2;
                case (op_q)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ir_out   = 1'b1;
                        mar_load = 1'b1;
                    end
                    OP_LDI: begin
                        ir_out = 1'b1;
                        a_load = 1'b1;
                    end
                    OP_JMP: begin
                        ir_out  = 1'b1;
                        pc_load = 1'b1;
                    end
                    OP_JC: begin
                        ir_out  = 1'b1;
                        pc_load = carry_flag;
                    end
                    OP_JZ: begin
                        ir_out  = 1'b1;
                        pc_load = zero_flag;
                    end
                    OP_OUT: begin
                        a_out    = 1'b1;
                        out_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            S2: begin
                step_out = STEP_W'(2);
                state_d  = (nsteps == 2'd2) ? DONE : S3;
                case (op_q)
                    OP_LDA: begin
                        ram_read = 1'b1;
                        a_load   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ram_read = 1'b1;
                        b_load   = 1'b1;
                    end
                    OP_STA: begin
                        a_out     = 1'b1;
                        ram_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            S3: begin
                step_out = STEP_W'(3);
                state_d  = DONE;
                if (op_q == OP_ADD || op_q == OP_SUB) begin
                    alu_out    = 1'b1;
                    a_load     = 1'b1;
                    flags_load = 1'b1;
                    alu_sub    = (op_q == OP_SUB);
                end
            end
            DONE: begin
                done    = 1'b1;
                // Zero-step opcodes other than NOP/HLT are undefined.
                illegal = (nsteps == 2'd0) && (op_q != OP_NOP)
                          && (op_q != OP_HLT);
                state_d = IDLE;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q != IDLE) && (state_q != HALT);
    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_execute_sequencer.sv
// Self-checking bench for execute_sequencer: directed vector table,
// hand-written corner sequences and randomized run against a model.
module tb_execute_sequencer;

    localparam logic [11:0] IR  = 12'h800;
    localparam logic [11:0] MAR = 12'h400;
    localparam logic [11:0] RR  = 12'h200;
    localparam logic [11:0] RW  = 12'h100;
    localparam logic [11:0] AL  = 12'h080;
    localparam logic [11:0] AO  = 12'h040;
    localparam logic [11:0] BL  = 12'h020;
    localparam logic [11:0] ALO = 12'h010;
    localparam logic [11:0] SB  = 12'h008;
    localparam logic [11:0] FL  = 12'h004;
    localparam logic [11:0] PC  = 12'h002;
    localparam logic [11:0] OUT = 12'h001;

    localparam int M_IDLE = 0;
    localparam int M_EXEC = 1;
    localparam int M_DONE = 2;
    localparam int M_HALT = 3;

    logic       clk = 1'b0;
    logic       rst, start, carry_flag, zero_flag;
    logic [3:0] opcode;
    logic       busy, done, halted, illegal;
    logic [1:0] step_out;
    logic       ir_out, mar_load, ram_read, ram_write, a_load, a_out;
    logic       b_load, alu_out, alu_sub, flags_load, pc_load, out_load;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    execute_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .busy(busy), .done(done), .halted(halted), .illegal(illegal),
        .step_out(step_out), .ir_out(ir_out), .mar_load(mar_load),
        .ram_read(ram_read), .ram_write(ram_write), .a_load(a_load),
        .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
        .alu_sub(alu_sub), .flags_load(flags_load), .pc_load(pc_load),
        .out_load(out_load)
    );

    always #5 clk = ~clk;

    logic [11:0] act_strb;
    logic [17:0] act_all;
    assign act_strb = {ir_out, mar_load, ram_read, ram_write, a_load, a_out,
                       b_load, alu_out, alu_sub, flags_load, pc_load, out_load};
    assign act_all  = {act_strb, done, busy, halted, illegal, step_out};

    function automatic logic [17:0] mk(input logic [11:0] s, input logic d,
                                       input logic b, input logic h,
                                       input logic il, input int st);
        return {s, d, b, h, il, st[1:0]};
    endfunction

    // Reference model: opcode -> list of per-step strobe words.
    logic [11:0] tbl [16][3];
    int          nsteps [16];
    int          m_mode = M_IDLE;
    int          m_step = 0;
    logic [3:0]  m_op   = 4'd0;

    initial begin
        for (int o = 0; o < 16; o++) begin
            nsteps[o] = 0;
            for (int s = 0; s < 3; s++) tbl[o][s] = 12'h000;
        end
        nsteps[1]  = 2; tbl[1][0]  = IR | MAR; tbl[1][1] = RR | AL;
        nsteps[2]  = 3; tbl[2][0]  = IR | MAR; tbl[2][1] = RR | BL;
        tbl[2][2]  = ALO | AL | FL;
        nsteps[3]  = 3; tbl[3][0]  = IR | MAR; tbl[3][1] = RR | BL;
        tbl[3][2]  = ALO | AL | FL | SB;
        nsteps[4]  = 2; tbl[4][0]  = IR | MAR; tbl[4][1] = AO | RW;
        nsteps[5]  = 1; tbl[5][0]  = IR | AL;
        nsteps[6]  = 1; tbl[6][0]  = IR | PC;
        nsteps[7]  = 1; tbl[7][0]  = IR;
        nsteps[8]  = 1; tbl[8][0]  = IR;
        nsteps[14] = 1; tbl[14][0] = AO | OUT;
    end

    function automatic logic [17:0] model_out();
        logic [11:0] s;
        s = 12'h000;
        case (m_mode)
            M_EXEC: begin
                s = tbl[m_op][m_step-1];
                if (m_op == 4'd7 && carry_flag) s = s | PC;
                if (m_op == 4'd8 && zero_flag)  s = s | PC;
                return mk(s, 1'b0, 1'b1, 1'b0, 1'b0, m_step);
            end
            M_DONE: return mk(s, 1'b1, 1'b1, 1'b0,
                              (m_op >= 4'd9 && m_op <= 4'd13), 0);
            M_HALT: return mk(s, 1'b0, 1'b0, 1'b1, 1'b0, 0);
            default: return mk(s, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode <= M_IDLE;
            m_step <= 0;
            m_op   <= 4'd0;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_op <= opcode;
                    if (opcode == 4'd15) m_mode <= M_HALT;
                    else if (nsteps[opcode] == 0) m_mode <= M_DONE;
                    else begin
                        m_mode <= M_EXEC;
                        m_step <= 1;
                    end
                end
                M_EXEC: if (m_step == nsteps[m_op]) m_mode <= M_DONE;
                        else m_step <= m_step + 1;
                M_DONE: m_mode <= M_IDLE;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act_all !== model_out()) begin
                errors++;
                $display("FAIL model t=%0t actual=%h required=%h",
                         $time, act_all, model_out());
            end
            checks++;
            if ($countones({ir_out, a_out, ram_read, alu_out}) > 1) begin
                errors++;
                $display("FAIL bus_excl t=%0t actual=%b required=<=1 driver",
                         $time, {ir_out, a_out, ram_read, alu_out});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [17:0] act,
                       input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]       op;
        logic             c;
        logic             z;
        int               n;
        logic [2:0][11:0] s;
        logic             il;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{4'd0,  0, 0, 0, {12'h0, 12'h0, 12'h0}, 0};
        vecs[1]  = '{4'd1,  0, 0, 2, {12'h0, RR | AL, IR | MAR}, 0};
        vecs[2]  = '{4'd2,  0, 0, 3, {ALO | AL | FL, RR | BL, IR | MAR}, 0};
        vecs[3]  = '{4'd3,  0, 0, 3,
                     {ALO | AL | FL | SB, RR | BL, IR | MAR}, 0};
        vecs[4]  = '{4'd4,  0, 0, 2, {12'h0, AO | RW, IR | MAR}, 0};
        vecs[5]  = '{4'd5,  0, 0, 1, {12'h0, 12'h0, IR | AL}, 0};
        vecs[6]  = '{4'd6,  0, 0, 1, {12'h0, 12'h0, IR | PC}, 0};
        vecs[7]  = '{4'd7,  0, 1, 1, {12'h0, 12'h0, IR}, 0};
        vecs[8]  = '{4'd7,  1, 0, 1, {12'h0, 12'h0, IR | PC}, 0};
        vecs[9]  = '{4'd8,  1, 0, 1, {12'h0, 12'h0, IR}, 0};
        vecs[10] = '{4'd8,  0, 1, 1, {12'h0, 12'h0, IR | PC}, 0};
        vecs[11] = '{4'd14, 0, 0, 1, {12'h0, 12'h0, AO | OUT}, 0};
        vecs[12] = '{4'd10, 0, 0, 0, {12'h0, 12'h0, 12'h0}, 1};
        vecs[13] = '{4'd13, 0, 0, 0, {12'h0, 12'h0, 12'h0}, 1};

        rst = 1'b1; start = 1'b0; opcode = 4'd0;
        carry_flag = 1'b0; zero_flag = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;
        chk("reset", act_all, mk(12'h0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            start = 1'b1; opcode = vecs[i].op;
            carry_flag = vecs[i].c; zero_flag = vecs[i].z;
            tick();
            start = 1'b0; opcode = 4'($urandom);
            for (int s = 0; s < vecs[i].n; s++) begin
                chk("vec_step", act_all, mk(vecs[i].s[s], 0, 1, 0, 0, s + 1));
                tick();
            end
            chk("vec_done", act_all, mk(12'h0, 1, 1, 0, vecs[i].il, 0));
            tick();
            chk("vec_idle", act_all, mk(12'h0, 0, 0, 0, 0, 0));
        end

        // Reset while ADD is in S2 aborts with no further strobes.
        start = 1'b1; opcode = 4'd2;
        tick();
        start = 1'b0;
        tick();
        chk("add_s2", act_all, mk(RR | BL, 0, 1, 0, 0, 2));
        rst = 1'b1;
        tick();
        chk("rst_abort", act_all, mk(12'h0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        tick();
        chk("rst_idle", act_all, mk(12'h0, 0, 0, 0, 0, 0));

        // Start held high through an LDA is ignored while busy.
        start = 1'b1; opcode = 4'd1;
        tick();
        opcode = 4'd2;
        chk("hold_s1", act_all, mk(IR | MAR, 0, 1, 0, 0, 1));
        tick();
        chk("hold_s2", act_all, mk(RR | AL, 0, 1, 0, 0, 2));
        tick();
        chk("hold_done", act_all, mk(12'h0, 1, 1, 0, 0, 0));
        start = 1'b0;
        tick();
        chk("hold_idle", act_all, mk(12'h0, 0, 0, 0, 0, 0));

        // HLT is sticky and ignores further starts until reset.
        start = 1'b1; opcode = 4'd15;
        tick();
        start = 1'b0;
        chk("halt", act_all, mk(12'h0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 20; i++) begin
            start = (i % 2 == 0); opcode = 4'd1;
            tick();
            chk("halt_hold", act_all, mk(12'h0, 0, 0, 1, 0, 0));
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("halt_clear", act_all, mk(12'h0, 0, 0, 0, 0, 0));

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            start      = ($urandom_range(0, 2) == 0);
            opcode     = 4'($urandom);
            carry_flag = 1'($urandom);
            zero_flag  = 1'($urandom);
            tick();
        end
        start = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
